// File: rtl/vga_axil_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axil_if
//  Brief    : AXI4-Lite signal bundle between the system master and the VGA
//             control/status register block.
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_axil_if #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
);
  // Write address channel
  logic [AXIL_ADDR_W-1:0]   awaddr;
  logic                     awvalid;
  logic                     awready;
  // Write data channel
  logic [AXIL_DATA_W-1:0]   wdata;
  logic [AXIL_DATA_W/8-1:0] wstrb;
  logic                     wvalid;
  logic                     wready;
  // Write response channel
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  // Read address channel
  logic [AXIL_ADDR_W-1:0]   araddr;
  logic                     arvalid;
  logic                     arready;
  // Read data channel
  logic [AXIL_DATA_W-1:0]   rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/vga_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axil_regs
//  Brief    : AXI4-Lite slave holding the VGA controller's control registers
//             (CTRL, BG/FG colour) and sticky frame-done status, plus a
//             read-only ID word.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_axil_regs #(
  parameter int          AXIL_ADDR_W = 32,
  parameter int          AXIL_DATA_W = 32,
  parameter logic [31:0] VGA_ID      = 32'h5647_4101
) (
  input  wire logic        clk,
  input  wire logic        arst,
  vga_axil_if.slave        axil,
  input  wire logic        frame_done_i,
  output logic             enable_o,
  output logic             test_pattern_o,
  output logic [11:0]      bg_color_o,
  output logic [11:0]      fg_color_o
);

  localparam int         c_strb_w     = AXIL_DATA_W / 8;
  localparam logic [2:0] c_idx_ctrl   = 3'd0;
  localparam logic [2:0] c_idx_bg     = 3'd1;
  localparam logic [2:0] c_idx_fg     = 3'd2;
  localparam logic [2:0] c_idx_status = 3'd3;
  localparam logic [2:0] c_idx_id     = 3'd4;
  localparam logic [1:0] c_resp_okay  = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                   r_ready_en;
  logic                   r_aw_held;
  logic [AXIL_ADDR_W-1:0] r_aw_addr;
  logic                   r_w_held;
  logic [AXIL_DATA_W-1:0] r_w_data;
  logic [c_strb_w-1:0]    r_w_strb;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic                   r_rvalid;
  logic [1:0]             r_rresp;
  logic [AXIL_DATA_W-1:0] r_rdata;
  logic [1:0]             r_ctrl;
  logic [11:0]            r_bg;
  logic [11:0]            r_fg;
  logic                   r_frame_pending;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic                   w_awready;
  logic                   w_wready;
  logic                   w_arready;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_ar_hs;
  logic [AXIL_ADDR_W-1:0] w_waddr;
  logic [AXIL_DATA_W-1:0] w_wdata;
  logic [c_strb_w-1:0]    w_wstrb;
  logic                   w_commit;
  logic [2:0]             w_widx;
  logic                   w_wmapped;
  logic                   w_wr_en;
  logic [1:0]             w_bresp_nxt;
  logic [2:0]             w_ridx;
  logic                   w_rmapped;
  logic [AXIL_DATA_W-1:0] w_rd_data;
  logic [1:0]             w_rresp_nxt;
  logic                   w_status_clr;
  logic                   w_unused;

  // Handshake readiness: one outstanding response per channel at a time.
  assign w_awready = r_ready_en && !r_aw_held && !r_bvalid;
  assign w_wready  = r_ready_en && !r_w_held  && !r_bvalid;
  assign w_arready = r_ready_en && !r_rvalid;

  assign w_aw_hs = axil.awvalid && w_awready;
  assign w_w_hs  = axil.wvalid  && w_wready;
  assign w_ar_hs = axil.arvalid && w_arready;

  // Held beats take priority over the live bus; a live beat only fills an
  // empty slot, so the two sources never compete.
  assign w_waddr = r_aw_held ? r_aw_addr : axil.awaddr;
  assign w_wdata = r_w_held  ? r_w_data  : axil.wdata;
  assign w_wstrb = r_w_held  ? r_w_strb  : axil.wstrb;

  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;

  assign w_widx    = w_waddr[4:2];
  assign w_wmapped = (w_waddr[AXIL_ADDR_W-1:5] == '0) && (w_widx <= c_idx_id);
  assign w_wr_en   = w_commit && w_wmapped && (w_widx != c_idx_id);

  assign w_status_clr = w_wr_en && (w_widx == c_idx_status) && w_wstrb[0] && w_wdata[0];

  assign w_ridx    = axil.araddr[4:2];
  assign w_rmapped = (axil.araddr[AXIL_ADDR_W-1:5] == '0) && (w_ridx <= c_idx_id);

  // Bits of the bus that no register implements.
  assign w_unused = ^{w_wdata[AXIL_DATA_W-1:12], w_wstrb[c_strb_w-1:2],
                      w_waddr[1:0], axil.araddr[1:0]};

  // Write response code: unmapped beats DECERR, the read-only ID SLVERR.
  always_comb begin
    w_bresp_nxt = c_resp_okay;
    if (!w_wmapped) begin
      w_bresp_nxt = c_resp_decerr;
    end else if (w_widx == c_idx_id) begin
      w_bresp_nxt = c_resp_slverr;
    end
  end

  // Read data mux; unimplemented bits stay zero.
  always_comb begin
    w_rd_data   = '0;
    w_rresp_nxt = c_resp_okay;
    if (!w_rmapped) begin
      w_rresp_nxt = c_resp_decerr;
    end else begin
      case (w_ridx)
        c_idx_ctrl:   w_rd_data[1:0]  = r_ctrl;
        c_idx_bg:     w_rd_data[11:0] = r_bg;
        c_idx_fg:     w_rd_data[11:0] = r_fg;
        c_idx_status: w_rd_data[0]    = r_frame_pending;
        c_idx_id:     w_rd_data       = AXIL_DATA_W'(VGA_ID);
        default:      w_rd_data       = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------

  // Readies stay low through reset and come up on the first edge after it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // One-entry AW and W holding slots, emptied when the write commits.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= axil.awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= axil.wdata;
        r_w_strb <= axil.wstrb;
      end
    end
  end

  // Write response: raised by a commit, held until the master takes it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_bresp_nxt;
    end else if (r_bvalid && axil.bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Control registers, byte-lane gated by the write strobes.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ctrl <= 2'b00;
      r_bg   <= 12'h000;
      r_fg   <= 12'h000;
    end else if (w_wr_en) begin
      case (w_widx)
        c_idx_ctrl: begin
          if (w_wstrb[0]) r_ctrl <= w_wdata[1:0];
        end
        c_idx_bg: begin
          if (w_wstrb[0]) r_bg[7:0]  <= w_wdata[7:0];
          if (w_wstrb[1]) r_bg[11:8] <= w_wdata[11:8];
        end
        c_idx_fg: begin
          if (w_wstrb[0]) r_fg[7:0]  <= w_wdata[7:0];
          if (w_wstrb[1]) r_fg[11:8] <= w_wdata[11:8];
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky frame-done flag; a new frame event beats a simultaneous clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_frame_pending <= 1'b0;
    end else if (frame_done_i) begin
      r_frame_pending <= 1'b1;
    end else if (w_status_clr) begin
      r_frame_pending <= 1'b0;
    end
  end

  // Read response: data captured at AR handshake, held until taken.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rresp_nxt;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && axil.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign axil.awready = w_awready;
  assign axil.wready  = w_wready;
  assign axil.arready = w_arready;
  assign axil.bvalid  = r_bvalid;
  assign axil.bresp   = r_bresp;
  assign axil.rvalid  = r_rvalid;
  assign axil.rresp   = r_rresp;
  assign axil.rdata   = r_rdata;

  assign enable_o       = r_ctrl[0];
  assign test_pattern_o = r_ctrl[1];
  assign bg_color_o     = r_bg;
  assign fg_color_o     = r_fg;

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_axil_regs
//  Brief    : Self-checking bench for vga_axil_regs: table of register
//             accesses with expected responses and core outputs, queued
//             B/R expectations, and directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_axil_regs;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        en;
    logic        tp;
    logic [11:0] bg;
    logic [11:0] fg;
  } vec_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic        clk;
  logic        arst;
  logic        frame_done_i;
  logic        enable_o;
  logic        test_pattern_o;
  logic [11:0] bg_color_o;
  logic [11:0] fg_color_o;

  int checks   = 0;
  int failures = 0;
  int b_count  = 0;
  int r_count  = 0;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  vec_t       tbl[20];

  vga_axil_if #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) bus ();

  vga_axil_regs #(
    .AXIL_ADDR_W(32),
    .AXIL_DATA_W(32),
    .VGA_ID     (32'h5647_4101)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .axil          (bus),
    .frame_done_i  (frame_done_i),
    .enable_o      (enable_o),
    .test_pattern_o(test_pattern_o),
    .bg_color_o    (bg_color_o),
    .fg_color_o    (fg_color_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something wedges beyond the bounded waits.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop one expectation per accepted B or R beat.
  always @(negedge clk) begin
    if (bus.bvalid && bus.bready) begin
      b_count++;
      chk("b_expected", 64'(bq.size() != 0), 64'd1);
      if (bq.size() != 0) chk("bresp", 64'(bus.bresp), 64'(bq.pop_front()));
    end
    if (bus.rvalid && bus.rready) begin
      rexp_t e;
      r_count++;
      chk("r_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        chk("rresp_rdata", 64'({bus.rresp, bus.rdata}), 64'({e.resp, e.data}));
      end
    end
  end

  task automatic drain_b();
    int n = 0;
    while (bq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain", 64'(bq.size()), 64'd0);
  endtask

  task automatic drain_r();
    int n = 0;
    while (rq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r_drain", 64'(rq.size()), 64'd0);
  endtask

  // AW and W presented together; fd pulses frame_done_i in the same cycle.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp,
                           input logic fd);
    logic aw_d, w_d, aw_now, w_now;
    int n;
    bq.push_back(resp);
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    frame_done_i = fd;
    aw_d = 1'b0; w_d = 1'b0; n = 0;
    while (!(aw_d && w_d) && n < 32) begin
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      frame_done_i = 1'b0;
      if (aw_now) begin aw_d = 1'b1; bus.awvalid = 1'b0; end
      if (w_now)  begin w_d  = 1'b1; bus.wvalid  = 1'b0; end
      n++;
      if (!(aw_d && w_d)) @(negedge clk);
    end
    chk("write_handshake", 64'(aw_d && w_d), 64'd1);
    @(negedge clk);
    chk("write_latency", 64'(bus.bvalid), 64'd1);
    drain_b();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] resp,
                          input logic [31:0] data);
    logic done, now;
    int n;
    rq.push_back('{resp: resp, data: data});
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 32) begin
      now = bus.arready;
      @(posedge clk); #1;
      if (now) begin done = 1'b1; bus.arvalid = 1'b0; end
      n++;
      if (!done) @(negedge clk);
    end
    chk("ar_handshake", 64'(done), 64'd1);
    @(negedge clk);
    chk("read_latency", 64'(bus.rvalid), 64'd1);
    drain_r();
  endtask

  initial begin
    int bc0, rc0;
    //          wr  addr           data           strb  resp   rdata          en   tp   bg      fg
    tbl[0]  = '{1'b0, 32'h10, 32'h0,          4'h0, 2'b00, 32'h5647_4101, 1'b0, 1'b0, 12'h000, 12'h000};
    tbl[1]  = '{1'b1, 32'h04, 32'h0000_0ABC,  4'hF, 2'b00, 32'h0,         1'b0, 1'b0, 12'hABC, 12'h000};
    tbl[2]  = '{1'b1, 32'h04, 32'h0000_0012,  4'h1, 2'b00, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h000};
    tbl[3]  = '{1'b0, 32'h04, 32'h0,          4'h0, 2'b00, 32'h0000_0A12, 1'b0, 1'b0, 12'hA12, 12'h000};
    tbl[4]  = '{1'b1, 32'h10, 32'hFFFF_FFFF,  4'hF, 2'b10, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h000};
    tbl[5]  = '{1'b0, 32'h10, 32'h0,          4'h0, 2'b00, 32'h5647_4101, 1'b0, 1'b0, 12'hA12, 12'h000};
    tbl[6]  = '{1'b1, 32'h14, 32'h0000_0123,  4'hF, 2'b11, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h000};
    tbl[7]  = '{1'b0, 32'h14, 32'h0,          4'h0, 2'b11, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h000};
    tbl[8]  = '{1'b1, 32'h08, 32'hFFFF_F123,  4'h3, 2'b00, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[9]  = '{1'b0, 32'h0A, 32'h0,          4'h0, 2'b00, 32'h0000_0123, 1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[10] = '{1'b1, 32'h20, 32'h0000_0001,  4'hF, 2'b11, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[11] = '{1'b0, 32'h24, 32'h0,          4'h0, 2'b11, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[12] = '{1'b1, 32'h03, 32'h0000_0003,  4'h2, 2'b00, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[13] = '{1'b0, 32'h00, 32'h0,          4'h0, 2'b00, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[14] = '{1'b1, 32'h1C, 32'h0000_000F,  4'hF, 2'b11, 32'h0,         1'b0, 1'b0, 12'hA12, 12'h123};
    tbl[15] = '{1'b1, 32'h00, 32'hFFFF_FFFE,  4'hF, 2'b00, 32'h0,         1'b0, 1'b1, 12'hA12, 12'h123};
    tbl[16] = '{1'b0, 32'h00, 32'h0,          4'h0, 2'b00, 32'h0000_0002, 1'b0, 1'b1, 12'hA12, 12'h123};
    tbl[17] = '{1'b1, 32'h04, 32'h0000_0F00,  4'h2, 2'b00, 32'h0,         1'b0, 1'b1, 12'hF12, 12'h123};
    tbl[18] = '{1'b0, 32'h04, 32'h0,          4'h0, 2'b00, 32'h0000_0F12, 1'b0, 1'b1, 12'hF12, 12'h123};
    tbl[19] = '{1'b0, 32'h0C, 32'h0,          4'h0, 2'b00, 32'h0,         1'b0, 1'b1, 12'hF12, 12'h123};

    arst = 1'b1; frame_done_i = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_handshake",
        64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}), 64'd0);
    chk("reset_outputs",
        64'({bus.rdata, enable_o, test_pattern_o, bg_color_o, fg_color_o}), 64'd0);
    arst = 1'b0;
    #1 chk("ready_before_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);

    // Register map table
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, 1'b0);
      else           axi_read(tbl[i].addr, tbl[i].resp, tbl[i].rdata);
      chk($sformatf("vec%0d_outs", i),
          64'({enable_o, test_pattern_o, bg_color_o, fg_color_o}),
          64'({tbl[i].en, tbl[i].tp, tbl[i].bg, tbl[i].fg}));
    end

    // W three cycles ahead of AW, response back-pressured for 4 cycles
    @(posedge clk); #1 bus.bready = 1'b0;
    bq.push_back(2'b00);
    bc0 = b_count;
    @(negedge clk);
    bus.wdata = 32'h0000_0003; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
    chk("wfirst_wready", 64'(bus.wready), 64'd1);
    @(posedge clk); #1 bus.wvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_held", 64'({bus.awready, bus.wready, bus.bvalid}), 64'b100);
    @(negedge clk);
    @(negedge clk);
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    chk("wfirst_awready", 64'(bus.awready), 64'd1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wfirst_bhold%0d", k), 64'({bus.bvalid, bus.awready, bus.wready}), 64'b100);
    end
    chk("wfirst_ctrl", 64'({enable_o, test_pattern_o}), 64'b11);
    @(posedge clk); #1 bus.bready = 1'b1;
    drain_b();
    repeat (3) @(negedge clk);
    chk("wfirst_single_b", 64'(b_count - bc0), 64'd1);
    chk("wfirst_ready_back", 64'({bus.awready, bus.wready}), 64'b11);
    axi_read(32'h00, 2'b00, 32'h0000_0003);

    // Sticky frame-done with write-1-to-clear
    @(negedge clk) frame_done_i = 1'b1;
    @(posedge clk); #1 frame_done_i = 1'b0;
    axi_read(32'h0C, 2'b00, 32'h1);
    axi_write(32'h0C, 32'h1, 4'h1, 2'b00, 1'b1);
    axi_read(32'h0C, 2'b00, 32'h1);
    axi_write(32'h0C, 32'h1, 4'h1, 2'b00, 1'b0);
    axi_read(32'h0C, 2'b00, 32'h0);

    // Reset with both responses outstanding
    @(posedge clk); #1 begin bus.bready = 1'b0; bus.rready = 1'b0; end
    @(negedge clk);
    bus.awaddr = 32'h04; bus.wdata = 32'h0000_0555; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h10; bus.arvalid = 1'b1;
    chk("midrst_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
    @(posedge clk); #1 begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; end
    @(negedge clk);
    chk("midrst_pending", 64'({bus.bvalid, bus.rvalid, bg_color_o}), 64'({2'b11, 12'h555}));
    arst = 1'b1;
    #1;
    chk("midrst_handshake",
        64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 64'd0);
    chk("midrst_outs", 64'({enable_o, test_pattern_o, bg_color_o, fg_color_o}), 64'd0);
    bus.bready = 1'b1; bus.rready = 1'b1;
    bc0 = b_count; rc0 = r_count;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
    repeat (4) @(negedge clk);
    chk("midrst_no_stale", {32'(b_count - bc0), 32'(r_count - rc0)}, 64'd0);
    axi_read(32'h04, 2'b00, 32'h0);
    axi_read(32'h0C, 2'b00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
